// File: rtl/reg_file_sb.sv
// Integer register file with hardwired x0, same-cycle writeback bypass and a
// per-register write-pending scoreboard that produces the decode stall.
module reg_file_sb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic             rs1_en,
    input  logic             rs2_en,
    output logic [XLEN-1:0]  rda,
    output logic [XLEN-1:0]  rdb,
    input  logic             reg_wrt,
    input  logic [AW-1:0]    rd,
    input  logic [XLEN-1:0]  wda,
    input  logic             iss_valid,
    input  logic [AW-1:0]    iss_rd,
    input  logic             flush,
    output logic             stall,
    output logic [NREGS-1:0] busy_vec
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             wr_en;
    logic             byp1;
    logic             byp2;
    logic             hit1;
    logic             hit2;

    assign wr_en = reg_wrt && (rd != '0);

    // Entry 0 is cleared by reset and never written, so it stays zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_en) begin
            regs_q[rd] <= wda;
        end
    end

    // Issue outranks a same-cycle writeback: the newer producer is still pending.
    always_comb begin
        busy_d    = busy_q;
        busy_d[0] = 1'b0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (iss_valid && (iss_rd == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (reg_wrt && (rd == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign byp1 = reg_wrt && (rd == rs1);
    assign byp2 = reg_wrt && (rd == rs2);

    always_comb begin
        rda = '0;
        if (rs1 != '0) begin
            rda = byp1 ? wda : regs_q[rs1];
        end
    end

    always_comb begin
        rdb = '0;
        if (rs2 != '0) begin
            rdb = byp2 ? wda : regs_q[rs2];
        end
    end

    assign hit1     = (rs1 != '0) && busy_q[rs1] && !byp1;
    assign hit2     = (rs2 != '0) && busy_q[rs2] && !byp2;
    assign stall    = (rs1_en && hit1) || (rs2_en && hit2);
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reset, x0, bypass, scoreboard and flush.
module tb_reg_file_sb;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, iss_rd = '0;
    logic        rs1_en = 1'b0, rs2_en = 1'b0, reg_wrt = 1'b0;
    logic        iss_valid = 1'b0, flush = 1'b0;
    logic [31:0] wda = '0;
    logic [31:0] rda, rdb, busy_vec;
    logic        stall;

    int checks = 0;
    int errors = 0;

    reg_file_sb #(.XLEN(32), .NREGS(32)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .rs1(rs1), .rs2(rs2), .rs1_en(rs1_en), .rs2_en(rs2_en),
        .rda(rda), .rdb(rdb),
        .reg_wrt(reg_wrt), .rd(rd), .wda(wda),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .stall(stall), .busy_vec(busy_vec)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        reg_wrt = 1'b0; iss_valid = 1'b0; flush = 1'b0;
        rs1_en = 1'b0; rs2_en = 1'b0;
    endtask

    initial begin
        #3 RST_N = 1'b0;
        #20;
        check("rst_busy", busy_vec, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();

        // x5 = DEADBEEF plus issue of x2, then asynchronous reset mid-run
        reg_wrt = 1'b1; rd = 5'd5; wda = 32'hDEADBEEF;
        iss_valid = 1'b1; iss_rd = 5'd2;
        tick();
        idle();
        rs1 = 5'd5; #1;
        check("x5_written", rda, 32'hDEADBEEF);
        check("x2_busy", busy_vec, 32'h0000_0004);
        #2 RST_N = 1'b0; #1;
        check("rst_mid_rda", rda, 32'h0);
        check("rst_mid_busy", busy_vec, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();

        // Write/read and x0 handling
        reg_wrt = 1'b1; rd = 5'd7; wda = 32'h1234_5678;
        tick();
        idle();
        rs1 = 5'd7; #1;
        check("x7_read", rda, 32'h1234_5678);
        reg_wrt = 1'b1; rd = 5'd0; wda = 32'hFFFF_FFFF; rs1 = 5'd0; #1;
        check("x0_no_bypass", rda, 32'h0);
        tick();
        idle(); #1;
        check("x0_after_write", rda, 32'h0);

        // Bypass on port B before the edge, then array after it
        rs2 = 5'd9;
        reg_wrt = 1'b1; rd = 5'd9; wda = 32'hA5A5_A5A5; #1;
        check("bypass_rdb", rdb, 32'hA5A5_A5A5);
        tick();
        idle(); wda = 32'h0; #1;
        check("x9_array", rdb, 32'hA5A5_A5A5);

        // Scoreboard on x3
        iss_valid = 1'b1; iss_rd = 5'd3; rs1 = 5'd3; rs1_en = 1'b1; #1;
        check("stall_same_cycle_issue", {31'b0, stall}, 32'h0);
        tick();
        idle(); rs1_en = 1'b1; #1;
        check("stall_rs1", {31'b0, stall}, 32'h1);
        rs1_en = 1'b0; #1;
        check("stall_rs1_unused", {31'b0, stall}, 32'h0);
        rs2 = 5'd3; rs2_en = 1'b1; #1;
        check("stall_rs2", {31'b0, stall}, 32'h1);
        rs2_en = 1'b0; rs1_en = 1'b1;
        reg_wrt = 1'b1; rd = 5'd3; wda = 32'h0000_0333; #1;
        check("wb_resolves_stall", {31'b0, stall}, 32'h0);
        check("wb_bypass_rda", rda, 32'h0000_0333);
        tick();
        idle(); #1;
        check("x3_cleared", busy_vec, 32'h0);
        check("x3_array", rda, 32'h0000_0333);

        // Issue beats same-cycle writeback; x0 never busy
        iss_valid = 1'b1; iss_rd = 5'd4; reg_wrt = 1'b1; rd = 5'd4; wda = 32'h44;
        tick();
        idle(); #1;
        check("issue_wins_x4", busy_vec, 32'h0000_0010);
        iss_valid = 1'b1; iss_rd = 5'd0;
        tick();
        idle(); #1;
        check("x0_never_busy", busy_vec, 32'h0000_0010);

        // Build 0xF0, then flush with a concurrent issue of x6
        for (int i = 5; i <= 7; i++) begin
            iss_valid = 1'b1; iss_rd = 5'(i);
            tick();
        end
        idle(); #1;
        check("busy_f0", busy_vec, 32'h0000_00F0);
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd6;
        tick();
        idle(); rs1 = 5'd7; rs2 = 5'd9; #1;
        check("flush_busy", busy_vec, 32'h0);
        check("flush_keeps_x7", rda, 32'h1234_5678);
        check("flush_keeps_x9", rdb, 32'hA5A5_A5A5);
        rs1 = 5'd4; #1;
        check("x4_value", rda, 32'h0000_0044);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
